// File: rtl/param_sync_fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO.
// Contents: default geometry and flag thresholds, plus a ceil-log2
// helper used to derive and cross-check the pointer width.
package param_sync_fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 64;
    localparam int FIFO_AW_DEF    = 6;
    localparam int FIFO_AF_DEF    = 60;
    localparam int FIFO_AE_DEF    = 4;

    function automatic int fifo_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/param_sync_fifo_ptr.sv
// Wrap-around binary pointer for the FIFO. One instance tracks the write
// address and another tracks the read address.
// Ports:
//   CLK   rising-edge clock
//   clr   asynchronous active-low reset
//   clear synchronous clear to zero (takes priority over inc)
//   inc   advance by one, wrapping modulo 2**AW
//   ptr   current pointer value
module param_sync_fifo_ptr
    import param_sync_fifo_pkg::*;
#(
    parameter int AW = FIFO_AW_DEF
) (
    input  logic          CLK,
    input  logic          clr,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // The power-of-two depth lets the natural AW-bit overflow do the wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and sticky
// overflow/underflow flags.
// Ports:
//   CLK, clr            clock, asynchronous active-low reset
//   flush               synchronous clear of pointers/count/errors
//   wr_en, wr_data      write request and data
//   rd_en               read request
//   rd_data, rd_valid   registered read data, valid one cycle after a pop
//   full, empty         count == DEPTH, count == 0
//   almost_full/empty   count >= AF_LEVEL, count <= AE_LEVEL
//   count               occupancy 0..DEPTH
//   overflow/underflow  sticky request-while-full / request-while-empty
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH_DEF,
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int AW       = FIFO_AW_DEF,
    parameter int AF_LEVEL = FIFO_AF_DEF,
    parameter int AE_LEVEL = FIFO_AE_DEF
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    if ((DEPTH != (1 << AW)) || (AW != fifo_clog2(DEPTH))) begin : g_bad_geometry
        $error("param_sync_fifo: DEPTH must equal 2**AW");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH) || (AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_levels
        $error("param_sync_fifo: almost-full/almost-empty level out of range");
    end

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q,    count_d;
    logic [WIDTH-1:0] rd_data_q,  rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_q,      ovf_d;
    logic             udf_q,      udf_d;
    logic             wr_acc;
    logic             rd_acc;

    always_comb begin
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);

        // Acceptance uses pre-edge flags, so a full FIFO still pops and an
        // empty one still pushes when both requests arrive together.
        wr_acc = wr_en & ~full  & ~flush;
        rd_acc = rd_en & ~empty & ~flush;

        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        ovf_d      = ovf_q | (wr_en & full);
        udf_d      = udf_q | (rd_en & empty);

        if (flush) begin
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (wr_acc && !rd_acc) begin
            count_d = count_q + (AW+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - (AW+1)'(1);
        end

        if (rd_acc) begin
            rd_data_d = mem_q[rd_ptr];
        end
    end

    param_sync_fifo_ptr #(.AW(AW)) u_wr_ptr (
        .CLK   (CLK),
        .clr   (clr),
        .clear (flush),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    param_sync_fifo_ptr #(.AW(AW)) u_rd_ptr (
        .CLK   (CLK),
        .clr   (clr),
        .clear (flush),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    // Storage has no reset; unwritten words can never be popped because
    // the count gates every read.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign count     = count_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 2;

    logic         CLK = 1'b0;
    logic         clr = 1'b0;
    logic         flush = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] rd_data;
    logic         rd_valid, full, empty, almost_full, almost_empty;
    logic [AW:0]  count;
    logic         overflow, underflow;

    param_sync_fifo #(
        .WIDTH(W), .DEPTH(D), .AW(AW), .AF_LEVEL(3), .AE_LEVEL(1)
    ) dut (
        .CLK          (CLK),
        .clr          (clr),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue plus the observable registers.
    logic [W-1:0] mq[$];
    logic         m_ovf = 1'b0, m_udf = 1'b0, m_rdv = 1'b0;
    logic [W-1:0] m_rdd = '0;

    typedef struct {
        logic fl, wr, rd;
        logic [7:0] d;
        int cnt;
        logic full, empty, af, ae, ovf, udf, rdv;
        logic [7:0] rdd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic fl, logic wr, logic rd, logic [7:0] d, int cnt,
                                logic fu, logic em, logic af, logic ae,
                                logic ovf, logic udf, logic rdv, logic [7:0] rdd);
        vec_t v;
        v.fl = fl; v.wr = wr; v.rd = rd; v.d = d; v.cnt = cnt;
        v.full = fu; v.empty = em; v.af = af; v.ae = ae;
        v.ovf = ovf; v.udf = udf; v.rdv = rdv; v.rdd = rdd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".count"}, 32'(count), 0);
        chk({tag, ".empty"}, 32'(empty), 1);
        chk({tag, ".full"}, 32'(full), 0);
        chk({tag, ".ae"}, 32'(almost_empty), 1);
        chk({tag, ".af"}, 32'(almost_full), 0);
        chk({tag, ".rdv"}, 32'(rd_valid), 0);
        chk({tag, ".rdd"}, 32'(rd_data), 0);
        chk({tag, ".ovf"}, 32'(overflow), 0);
        chk({tag, ".udf"}, 32'(underflow), 0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_rdv = 1'b0; m_rdd = '0;
    endtask

    task automatic model_step(input logic fl, input logic wr, input logic rd, input logic [W-1:0] d);
        int n;
        n = mq.size();
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_rdv = 1'b0;
        end else begin
            if (wr && n == D) m_ovf = 1'b1;
            if (rd && n == 0) m_udf = 1'b1;
            m_rdv = rd && (n != 0);
            if (m_rdv) m_rdd = mq.pop_front();
            if (wr && n != D) mq.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == D));
        chk({tag, ".ae"}, 32'(almost_empty), 32'(n <= 1));
        chk({tag, ".af"}, 32'(almost_full), 32'(n >= 3));
        chk({tag, ".rdv"}, 32'(rd_valid), 32'(m_rdv));
        chk({tag, ".rdd"}, 32'(rd_data), 32'(m_rdd));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic drive_step(input logic fl, input logic wr, input logic rd, input logic [W-1:0] d);
        flush = fl; wr_en = wr; rd_en = rd; wr_data = d;
        @(posedge CLK);
        #1;
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic mstep(input string tag, input logic fl, input logic wr, input logic rd, input logic [W-1:0] d);
        drive_step(fl, wr, rd, d);
        model_step(fl, wr, rd, d);
        check_model(tag);
    endtask

    initial begin
        // Directed table: fill/overflow, drain/underflow, flush,
        // simultaneous requests at both ends, then pointer wrap.
        tbl.push_back(mk(0,1,0,8'hA1, 1,0,0,0,1, 0,0,0,8'h00));
        tbl.push_back(mk(0,1,0,8'hA2, 2,0,0,0,0, 0,0,0,8'h00));
        tbl.push_back(mk(0,1,0,8'hA3, 3,0,0,1,0, 0,0,0,8'h00));
        tbl.push_back(mk(0,1,0,8'hA4, 4,1,0,1,0, 0,0,0,8'h00));
        tbl.push_back(mk(0,1,0,8'hA5, 4,1,0,1,0, 1,0,0,8'h00));
        tbl.push_back(mk(0,0,1,8'h00, 3,0,0,1,0, 1,0,1,8'hA1));
        tbl.push_back(mk(0,0,1,8'h00, 2,0,0,0,0, 1,0,1,8'hA2));
        tbl.push_back(mk(0,0,1,8'h00, 1,0,0,0,1, 1,0,1,8'hA3));
        tbl.push_back(mk(0,0,1,8'h00, 0,0,1,0,1, 1,0,1,8'hA4));
        tbl.push_back(mk(0,0,1,8'h00, 0,0,1,0,1, 1,1,0,8'hA4));
        tbl.push_back(mk(1,0,0,8'h00, 0,0,1,0,1, 0,0,0,8'hA4));
        tbl.push_back(mk(0,1,0,8'hB1, 1,0,0,0,1, 0,0,0,8'hA4));
        tbl.push_back(mk(0,1,0,8'hB2, 2,0,0,0,0, 0,0,0,8'hA4));
        tbl.push_back(mk(0,1,0,8'hB3, 3,0,0,1,0, 0,0,0,8'hA4));
        tbl.push_back(mk(0,1,0,8'hB4, 4,1,0,1,0, 0,0,0,8'hA4));
        tbl.push_back(mk(0,1,1,8'hB5, 3,0,0,1,0, 1,0,1,8'hB1));
        tbl.push_back(mk(1,0,0,8'h00, 0,0,1,0,1, 0,0,0,8'hB1));
        tbl.push_back(mk(0,1,1,8'hC1, 1,0,0,0,1, 0,1,0,8'hB1));
        tbl.push_back(mk(0,0,0,8'h00, 1,0,0,0,1, 0,1,0,8'hB1));
        tbl.push_back(mk(0,1,0,8'hC2, 2,0,0,0,0, 0,1,0,8'hB1));
        tbl.push_back(mk(0,1,1,8'hD0, 2,0,0,0,0, 0,1,1,8'hC1));
        tbl.push_back(mk(0,1,1,8'hD1, 2,0,0,0,0, 0,1,1,8'hC2));
        tbl.push_back(mk(0,1,1,8'hD2, 2,0,0,0,0, 0,1,1,8'hD0));
        tbl.push_back(mk(0,1,1,8'hD3, 2,0,0,0,0, 0,1,1,8'hD1));
        tbl.push_back(mk(0,1,1,8'hD4, 2,0,0,0,0, 0,1,1,8'hD2));
        tbl.push_back(mk(0,1,1,8'hD5, 2,0,0,0,0, 0,1,1,8'hD3));

        // Reset held, then released between edges.
        clr = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("in_reset");
        #2 clr = 1'b1;
        @(posedge CLK);
        #1;
        check_reset_outputs("after_release");

        foreach (tbl[i]) begin
            drive_step(tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].d);
            chk($sformatf("v%0d.count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d.full", i), 32'(full), 32'(tbl[i].full));
            chk($sformatf("v%0d.empty", i), 32'(empty), 32'(tbl[i].empty));
            chk($sformatf("v%0d.af", i), 32'(almost_full), 32'(tbl[i].af));
            chk($sformatf("v%0d.ae", i), 32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("v%0d.udf", i), 32'(underflow), 32'(tbl[i].udf));
            chk($sformatf("v%0d.rdv", i), 32'(rd_valid), 32'(tbl[i].rdv));
            chk($sformatf("v%0d.rdd", i), 32'(rd_data), 32'(tbl[i].rdd));
        end

        // Asynchronous reset with data held: outputs must clear without an edge.
        #2 clr = 1'b0;
        #1;
        check_reset_outputs("async_clr");
        #2 clr = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        check_model("post_clr");

        // Both error flags set with three words held, then flush.
        mstep("s6_udf", 0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) mstep($sformatf("s6_wr%0d", i), 0, 1, 0, 8'h60 + 8'(i));
        mstep("s6_rd", 0, 0, 1, 8'h00);
        chk("s6_count3", 32'(count), 3);
        mstep("s6_flush", 1, 0, 0, 8'h00);
        mstep("s6_rd_after_flush", 0, 0, 1, 8'h00);

        // Reset asserted in the middle of a write burst.
        mstep("s6_burst0", 0, 1, 0, 8'h71);
        mstep("s6_burst1", 0, 1, 0, 8'h72);
        wr_en = 1'b1; wr_data = 8'h73;
        #2 clr = 1'b0;
        #1;
        check_reset_outputs("burst_clr");
        @(posedge CLK);
        #1;
        check_reset_outputs("burst_clr_edge");
        wr_en = 1'b0;
        #2 clr = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        check_model("burst_release");
        mstep("burst_rd_empty", 0, 0, 1, 8'h00);

        // Randomised traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic fl, wr, rd;
            logic [W-1:0] d;
            fl = ($urandom_range(0, 29) == 0);
            wr = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 50);
            d  = W'($urandom);
            mstep($sformatf("rnd%0d", i), fl, wr, rd, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
